bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single external bus (bus_query_req_t / bus_query_resp_t) among N_MASTER requesters, e.g. the instruction-fetch cache and the data cache / MMU walker.
- Grants one master per complete transaction, either a read burst or a write burst.
- Routes that master's request to the slave port and the slave response back to it.
- Tracks burst beats and flags protocol violations.

Parameters:
- N_MASTER, 2, number of requesting masters; index 0 is highest fixed priority.
- CNT_W, 5, width of the beat counter; must hold 16.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- m_req  input  N_MASTER x bus_query_req_t  per-master bus requests
- m_resp  output  N_MASTER x bus_query_resp_t  per-master bus responses
- s_req  output  bus_query_req_t  request to the bus slave / memory controller
- s_resp  input  bus_query_resp_t  response from the slave
- grant  output  N_MASTER  one-hot current owner; 0 when idle
- busy  output  1  a transaction is in progress
- protocol_err  output  1  one-cycle pulse on a burst length mismatch

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, grant=0, busy=0, protocol_err=0.
  - beat counter=0, latched length=0, round-robin pointer=0.
  - s_req all-zero; every m_resp all-zero.
- Request detection: master i requests when m_req[i].awvalid=1 with wlen!=0, or m_req[i].arvalid=1 with rlen!=0.
  - awvalid/arvalid with a zero length is ignored and is never granted.
- States: IDLE, WRITE, READ.
- IDLE:
  - s_req is all-zero.
  - If any master requests, select the winner, register grant, latch wlen or rlen, clear the beat counter.
  - Next state is WRITE if the winner has a valid write, otherwise READ.
  - Write wins over read when one master asserts both.
  - Arbitration latency: grant and s_req are visible the cycle after the request is first seen.
- WRITE:
  - s_req carries the granted master's write fields.
  - arvalid and rready are forced to 0, and the read fields are zeroed.
  - The granted master's m_resp = s_resp with rvalid/rlast/rdata forced to 0.
  - Beat counter increments on wvalid & s_resp.wready.
  - Done on s_resp.bvalid & bready: go to IDLE, clear grant.
  - protocol_err pulses at done if the counted beats differ from the latched wlen.
- READ:
  - s_req carries the granted master's read fields.
  - awvalid/wvalid/bready are forced to 0.
  - The granted master's m_resp = s_resp with awready/wready/bvalid forced to 0.
  - Beat counter increments on s_resp.rvalid & m_req.rready.
  - Done on an accepted beat that carries rlast, or on the beat that makes count == latched rlen, whichever comes first.
  - protocol_err pulses if rlast and the count reaching rlen do not occur on the same beat.
- Masters that are not granted always receive all-zero m_resp; their requests are held pending with no side effects.
- The grant is locked for the whole transaction; a request from a higher-priority master does not preempt.
- Minimum of one IDLE bubble cycle between consecutive transactions, because the completion cycle returns to IDLE.
- busy=1 in WRITE and READ.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs zeroed; the partial burst is abandoned and the slave is required to be reset by the same rst.
- Beat counter saturates at 16.

Optional Feature:
- Macro BUS_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - The pointer records the last winner; the search starts at pointer+1 modulo N_MASTER.
  - The pointer updates when a grant is issued.
- Undefined: fixed priority, lowest index wins; the pointer logic is absent.

Test Plan:
- Single read: m0 arvalid, rlen=4, araddr=0x0_0000_1000; slave returns 4 beats with rlast on the 4th -> grant=01 one cycle after the request; m0 sees 4 rdata beats; state returns to IDLE; protocol_err=0.
- Contention: m0 read rlen=1 and m1 write wlen=2 in the same cycle.
  - Fixed priority: m0 is served first, then m1 after a 1-cycle bubble.
  - Round-robin with pointer=0: m1 is served first.
- Write burst: m1 wlen=16, 16 beats with wready, then bvalid -> busy=1 throughout, m0 m_resp stays zero, protocol_err=0, beat counter reaches 16.
- Length mismatch: read rlen=4, slave asserts rlast on beat 2 -> transaction ends at beat 2, protocol_err pulses one cycle.
- Zero length: m0 arvalid with rlen=0 -> no grant, s_req stays zero, busy=0.
- Reset mid-READ after 2 of 8 beats -> same cycle: grant=0, s_req zeroed; after release, a new request is arbitrated normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: grants one master per read or write burst and counts beats.
// Optional BUS_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed-priority arbitration.

package bus_arbiter_pkg;

  parameter int unsigned BUS_ADDR_W = 36;
  parameter int unsigned BUS_DATA_W = 32;
  parameter int unsigned BUS_LEN_W  = 5;

  typedef struct packed {
    logic                  awvalid;
    logic [BUS_ADDR_W-1:0] awaddr;
    logic [BUS_LEN_W-1:0]  wlen;
    logic                  wvalid;
    logic [BUS_DATA_W-1:0] wdata;
    logic                  wlast;
    logic                  bready;
    logic                  arvalid;
    logic [BUS_ADDR_W-1:0] araddr;
    logic [BUS_LEN_W-1:0]  rlen;
    logic                  rready;
  } bus_query_req_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic                  bvalid;
    logic                  arready;
    logic                  rvalid;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  rlast;
  } bus_query_resp_t;

endpackage

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTER = 2,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  bus_query_req_t  [N_MASTER-1:0]   m_req,
  output bus_query_resp_t [N_MASTER-1:0]   m_resp,
  output bus_query_req_t                   s_req,
  input  bus_query_resp_t                  s_resp,
  output logic            [N_MASTER-1:0]   grant,
  output logic                             busy,
  output logic                             protocol_err
);

  localparam int unsigned IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(16);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e              state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_sat;

  logic [N_MASTER-1:0] req_vec;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic                win_wr;
  logic                len_hit;
  bus_query_req_t      g_req;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [31:0]      cand;
`endif

  // A zero-length request is not a request at all.
  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      req_vec[i] = (m_req[i].awvalid && (m_req[i].wlen != '0)) ||
                   (m_req[i].arvalid && (m_req[i].rlen != '0));
    end
  end

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    cand = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      cand = (32'(ptr_q) + 32'(k) + 32'd1) % N_MASTER;
      if (!win_found && req_vec[IDX_W'(cand)]) begin
        win_idx   = IDX_W'(cand);
        win_found = 1'b1;
      end
    end
`else
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_idx   = IDX_W'(i);
        win_found = 1'b1;
      end
    end
`endif
  end

  assign win_wr  = m_req[win_idx].awvalid && (m_req[win_idx].wlen != '0);
  assign g_req   = m_req[idx_q];
  assign cnt_sat = (cnt_q >= CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    s_req        = '0;
    m_resp       = '0;
    protocol_err = 1'b0;
    len_hit      = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    ptr_d        = ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          cnt_d            = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          ptr_d            = win_idx;
`endif
          if (win_wr) begin
            state_d = StWrite;
            len_d   = CNT_W'(m_req[win_idx].wlen);
          end else begin
            state_d = StRead;
            len_d   = CNT_W'(m_req[win_idx].rlen);
          end
        end
      end

      StWrite: begin
        s_req         = g_req;
        s_req.arvalid = 1'b0;
        s_req.araddr  = '0;
        s_req.rlen    = '0;
        s_req.rready  = 1'b0;

        m_resp[idx_q]        = s_resp;
        m_resp[idx_q].rvalid = 1'b0;
        m_resp[idx_q].rlast  = 1'b0;
        m_resp[idx_q].rdata  = '0;

        if (g_req.wvalid && s_resp.wready) begin
          cnt_d = cnt_sat;
        end
        // cnt_d already includes a beat accepted in the same cycle as the response.
        if (s_resp.bvalid && g_req.bready) begin
          state_d      = StIdle;
          grant_d      = '0;
          protocol_err = (cnt_d != len_q);
        end
      end

      StRead: begin
        s_req         = g_req;
        s_req.awvalid = 1'b0;
        s_req.awaddr  = '0;
        s_req.wlen    = '0;
        s_req.wvalid  = 1'b0;
        s_req.wdata   = '0;
        s_req.wlast   = 1'b0;
        s_req.bready  = 1'b0;

        m_resp[idx_q]         = s_resp;
        m_resp[idx_q].awready = 1'b0;
        m_resp[idx_q].wready  = 1'b0;
        m_resp[idx_q].bvalid  = 1'b0;

        if (s_resp.rvalid && g_req.rready) begin
          cnt_d   = cnt_sat;
          len_hit = (cnt_sat == len_q);
          // Whichever of rlast or the length count comes first ends the burst.
          if (s_resp.rlast || len_hit) begin
            state_d      = StIdle;
            grant_d      = '0;
            protocol_err = (s_resp.rlast != len_hit);
          end
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected grant/beat/error events,
// a negedge monitor pops and compares them as the DUT presents them.

module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned NM = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  bus_query_req_t  [NM-1:0]     m_req;
  bus_query_resp_t [NM-1:0]     m_resp;
  bus_query_req_t               s_req;
  bus_query_resp_t              s_resp;
  logic            [NM-1:0]     grant;
  logic                         busy;
  logic                         protocol_err;

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_MASTER (NM),
    .CNT_W    (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_req        (m_req),
    .m_resp       (m_resp),
    .s_req        (s_req),
    .s_resp       (s_resp),
    .grant        (grant),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  typedef enum int {EvGrant, EvBeat, EvErr} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [63:0] data;
    string       name;
  } ev_t;

  ev_t           exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            mon_en  = 1'b0;
  logic [NM-1:0] mon_prev_grant;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void push(ev_kind_e k, logic [63:0] d, string n);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.name = n;
    exp_q.push_back(e);
  endfunction

  function automatic logic [63:0] beat_word(int m, logic last, logic [31:0] d);
    return {27'd0, 4'(m), last, d};
  endfunction

  function automatic void got(ev_kind_e k, logic [63:0] d);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0h, required no event", k, d);
    end else begin
      n_tests--;
      e = exp_q.pop_front();
      chk({e.name, "_kind"}, 64'(k), 64'(e.kind));
      chk(e.name, d, e.data);
    end
  endfunction

  // Monitor: grant changes, every delivered read beat, and error pulses.
  initial begin
    mon_prev_grant = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (grant !== mon_prev_grant) begin
          got(EvGrant, 64'(grant));
          mon_prev_grant = grant;
        end
        for (int m = 0; m < NM; m++) begin
          if (m_resp[m].rvalid === 1'b1) begin
            got(EvBeat, beat_word(m, m_resp[m].rlast, m_resp[m].rdata));
          end
        end
        if (protocol_err === 1'b1) got(EvErr, 64'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave returns n beats, rlast on beat last_at (0: never); junk write handshakes must be masked.
  task automatic read_beats(int m, int n, int last_at, bit exp_err);
    logic [31:0] d;
    for (int k = 1; k <= n; k++) begin
      d               = 32'hD000_0000 | (32'(m) << 8) | 32'(k);
      s_resp          = '0;
      s_resp.rvalid   = 1'b1;
      s_resp.rdata    = d;
      s_resp.rlast    = (k == last_at);
      s_resp.wready   = 1'b1;
      s_resp.bvalid   = 1'b1;
      m_req[m].wvalid = 1'b1;
      #1;
      chk("rd_wready_masked", 64'(m_resp[m].wready), 64'd0);
      chk("rd_bvalid_masked", 64'(m_resp[m].bvalid), 64'd0);
      chk("rd_s_wvalid_zero", 64'(s_req.wvalid), 64'd0);
      push(EvBeat, beat_word(m, (k == last_at), d), "rbeat");
      if (k == n && exp_err) push(EvErr, 64'd1, "rd_protocol_err");
      step();
    end
    s_resp          = '0;
    m_req[m].wvalid = 1'b0;
  endtask

  // n write beats with wready, then a write response; junk read data must be masked.
  task automatic write_beats(int m, int n, bit exp_err);
    m_req[m].wvalid = 1'b1;
    for (int k = 1; k <= n; k++) begin
      m_req[m].wdata = 32'hC000_0000 + 32'(k);
      m_req[m].wlast = (k == n);
      s_resp         = '0;
      s_resp.wready  = 1'b1;
      s_resp.rvalid  = 1'b1;
      s_resp.rdata   = 32'hBAD0_0000;
      #1;
      chk("wr_busy", 64'(busy), 64'd1);
      chk("wr_s_wdata", 64'(s_req.wdata), 64'(32'hC000_0000 + 32'(k)));
      chk("wr_s_rready_zero", 64'(s_req.rready), 64'd0);
      chk("wr_other_resp_zero", 64'(|m_resp[1-m]), 64'd0);
      step();
    end
    m_req[m].wvalid = 1'b0;
    m_req[m].wlast  = 1'b0;
    s_resp          = '0;
    s_resp.bvalid   = 1'b1;
    if (exp_err) push(EvErr, 64'd1, "wr_protocol_err");
    step();
    s_resp = '0;
  endtask

  initial begin
    rst    = 1'b0;
    m_req  = '0;
    s_resp = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(protocol_err), 64'd0);
    chk("rst_s_req", 64'(|s_req), 64'd0);
    chk("rst_m_resp", 64'(|m_resp), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Single read: m0, 4 beats, rlast on 4th.
    step();
    m_req[0].arvalid = 1'b1;
    m_req[0].rlen    = 5'd4;
    m_req[0].araddr  = 36'h0_0000_1000;
    m_req[0].rready  = 1'b1;
    push(EvGrant, 64'd1, "s1_grant");
    step();
    chk("s1_grant_latency", 64'(grant), 64'd1);
    chk("s1_araddr", 64'(s_req.araddr), 64'h1000);
    m_req[0].arvalid = 1'b0;
    read_beats(0, 4, 4, 1'b0);
    push(EvGrant, 64'd0, "s1_release");
    chk("s1_idle_busy", 64'(busy), 64'd0);
    step();

    // Contention: m0 read rlen=1 against m1 write wlen=2.
    m_req[0].arvalid = 1'b1;
    m_req[0].rlen    = 5'd1;
    m_req[1].awvalid = 1'b1;
    m_req[1].wlen    = 5'd2;
    m_req[1].awaddr  = 36'h0_0000_2000;
    m_req[1].bready  = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    push(EvGrant, 64'd2, "s2_grant_m1");
    step();
    chk("s2_first_m1", 64'(grant), 64'd2);
    m_req[1].awvalid = 1'b0;
    write_beats(1, 2, 1'b0);
    push(EvGrant, 64'd0, "s2_release_m1");
    push(EvGrant, 64'd1, "s2_grant_m0");
    chk("s2_bubble", 64'(grant), 64'd0);
    step();
    chk("s2_second_m0", 64'(grant), 64'd1);
    m_req[0].arvalid = 1'b0;
    read_beats(0, 1, 1, 1'b0);
    push(EvGrant, 64'd0, "s2_release_m0");
`else
    push(EvGrant, 64'd1, "s2_grant_m0");
    step();
    chk("s2_first_m0", 64'(grant), 64'd1);
    m_req[0].arvalid = 1'b0;
    read_beats(0, 1, 1, 1'b0);
    push(EvGrant, 64'd0, "s2_release_m0");
    push(EvGrant, 64'd2, "s2_grant_m1");
    chk("s2_bubble", 64'(grant), 64'd0);
    step();
    chk("s2_second_m1", 64'(grant), 64'd2);
    m_req[1].awvalid = 1'b0;
    write_beats(1, 2, 1'b0);
    push(EvGrant, 64'd0, "s2_release_m1");
`endif
    step();

    // 16-beat write burst from m1.
    m_req[1].awvalid = 1'b1;
    m_req[1].wlen    = 5'd16;
    push(EvGrant, 64'd2, "s3_grant");
    step();
    chk("s3_grant", 64'(grant), 64'd2);
    m_req[1].awvalid = 1'b0;
    write_beats(1, 16, 1'b0);
    push(EvGrant, 64'd0, "s3_release");
    chk("s3_beat_count", 64'(dut.cnt_q), 64'd16);
    step();

    // Early rlast: rlen=4, rlast on beat 2.
    m_req[0].arvalid = 1'b1;
    m_req[0].rlen    = 5'd4;
    push(EvGrant, 64'd1, "s4_grant");
    step();
    m_req[0].arvalid = 1'b0;
    read_beats(0, 2, 2, 1'b1);
    push(EvGrant, 64'd0, "s4_release");
    chk("s4_err_one_cycle", 64'(protocol_err), 64'd0);
    step();

    // Zero-length requests are never granted.
    m_req[0].arvalid = 1'b1;
    m_req[0].rlen    = 5'd0;
    m_req[1].awvalid = 1'b1;
    m_req[1].wlen    = 5'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("s5_grant", 64'(grant), 64'd0);
      chk("s5_busy", 64'(busy), 64'd0);
      chk("s5_s_req", 64'(|s_req), 64'd0);
    end
    m_req[0].arvalid = 1'b0;
    m_req[1].awvalid = 1'b0;
    step();

    // Reset mid-read after 2 of 8 beats, then a fresh write is arbitrated.
    m_req[0].arvalid = 1'b1;
    m_req[0].rlen    = 5'd8;
    push(EvGrant, 64'd1, "s6_grant");
    step();
    m_req[0].arvalid = 1'b0;
    read_beats(0, 2, 0, 1'b0);
    chk("s6_still_busy", 64'(busy), 64'd1);
    push(EvGrant, 64'd0, "s6_reset_release");
    rst = 1'b1;
    #1;
    chk("s6_rst_grant", 64'(grant), 64'd0);
    chk("s6_rst_busy", 64'(busy), 64'd0);
    chk("s6_rst_s_req", 64'(|s_req), 64'd0);
    chk("s6_rst_m_resp", 64'(|m_resp), 64'd0);
    step();
    rst = 1'b0;
    m_req[1].awvalid = 1'b1;
    m_req[1].wlen    = 5'd1;
    push(EvGrant, 64'd2, "s6_regrant");
    step();
    chk("s6_regrant", 64'(grant), 64'd2);
    m_req[1].awvalid = 1'b0;
    write_beats(1, 1, 1'b0);
    push(EvGrant, 64'd0, "s6_release");
    repeat (3) step();

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
